// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, one 8-bit word per frame on o_tx.
// Frame: start(0), 8 data bits (lsb- or msb-first), even parity, 1 or 2 stop bits,
// then GUARD_BITS idle bit periods. Optional line-break support is compiled in
// with `define UART_TX_BREAK_EN (adds input i_break).
module uart_tx #(
  parameter int unsigned GUARD_BITS = 0
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic [31:0] i_bit_length,
  input  logic        i_hw_flow_control_enable,
  input  logic        i_msb_first,
  input  logic [1:0]  i_stop_bit_mode,
  input  logic        i_tx_valid,
  input  logic [7:0]  i_tx_word,
  output logic        o_tx_ready,
  output logic        o_tx_busy,
  output logic        o_tx_done,
`ifdef UART_TX_BREAK_EN
  input  logic        i_break,
`endif
  input  logic        i_cts,
  output logic        o_tx
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2, S_GUARD, S_BREAK, S_BRK_REL
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] len;
  logic [7:0]  word;
  logic        msb;
  logic        two_stop;
  logic [2:0]  idx;

  logic [31:0] len_in;
  logic [31:0] guard_load;
  logic [2:0]  idx_nxt;
  logic        last_bit;
  logic        cts_ok;
  logic        brk;
  logic        accept;
  logic        timed;

`ifdef UART_TX_BREAK_EN
  assign brk = i_break;
`else
  assign brk = 1'b0;
`endif

  // A zero bit length would stall the timer; run it as one clock per bit.
  assign len_in     = (i_bit_length == 32'd0) ? 32'd1 : i_bit_length;
  assign guard_load = GUARD_BITS * len - 32'd1;
  assign idx_nxt    = msb ? idx - 3'd1 : idx + 3'd1;
  assign last_bit   = msb ? (idx == 3'd0) : (idx == 3'd7);
  assign cts_ok     = !i_hw_flow_control_enable || !i_cts;
  // Ready is held low while reset is asserted even though the state reads IDLE.
  assign o_tx_ready = i_nrst && (state == S_IDLE) && cts_ok && !brk;
  assign accept     = i_tx_valid && o_tx_ready;
  assign o_tx_busy  = (state != S_IDLE);
  assign timed      = !(state == S_IDLE || state == S_BREAK);

  // True for the state whose last cycle ends the frame (carries the done pulse).
  function automatic logic is_final(input state_t s, input logic two);
    if (s == S_GUARD) return 1'b1;
    if (GUARD_BITS != 0) return 1'b0;
    return (s == S_STOP && !two) || (s == S_STOP2);
  endfunction

  // Frame FSM; o_tx and o_tx_done are registered with one-cycle lookahead.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state     <= S_IDLE;
      cnt       <= 32'd0;
      len       <= 32'd0;
      word      <= 8'd0;
      msb       <= 1'b0;
      two_stop  <= 1'b0;
      idx       <= 3'd0;
      o_tx      <= 1'b1;
      o_tx_done <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      if (timed && cnt != 32'd0) begin
        cnt       <= cnt - 32'd1;
        o_tx_done <= is_final(state, two_stop) && (cnt == 32'd1);
      end else begin
        case (state)
          S_IDLE: begin
            if (brk) begin
              state <= S_BREAK;
              o_tx  <= 1'b0;
            end else if (accept) begin
              state    <= S_START;
              o_tx     <= 1'b0;
              word     <= i_tx_word;
              len      <= len_in;
              msb      <= i_msb_first;
              two_stop <= (i_stop_bit_mode == 2'b01);
              idx      <= i_msb_first ? 3'd7 : 3'd0;
              cnt      <= len_in - 32'd1;
            end
          end
          S_START: begin
            state <= S_DATA;
            o_tx  <= word[idx];
            cnt   <= len - 32'd1;
          end
          S_DATA: begin
            cnt <= len - 32'd1;
            if (last_bit) begin
              state <= S_PARITY;
              o_tx  <= ^word;
            end else begin
              idx  <= idx_nxt;
              o_tx <= word[idx_nxt];
            end
          end
          S_PARITY: begin
            state     <= S_STOP;
            o_tx      <= 1'b1;
            cnt       <= len - 32'd1;
            o_tx_done <= is_final(S_STOP, two_stop) && (len == 32'd1);
          end
          S_STOP: begin
            if (two_stop) begin
              state     <= S_STOP2;
              cnt       <= len - 32'd1;
              o_tx_done <= is_final(S_STOP2, two_stop) && (len == 32'd1);
            end else if (GUARD_BITS != 0) begin
              state     <= S_GUARD;
              cnt       <= guard_load;
              o_tx_done <= (guard_load == 32'd0);
            end else begin
              state <= S_IDLE;
            end
          end
          S_STOP2: begin
            if (GUARD_BITS != 0) begin
              state     <= S_GUARD;
              cnt       <= guard_load;
              o_tx_done <= (guard_load == 32'd0);
            end else begin
              state <= S_IDLE;
            end
          end
          S_GUARD:   state <= S_IDLE;
          // Break release: line goes idle, then one full bit period before ready.
          S_BREAK: begin
            if (!brk) begin
              state <= S_BRK_REL;
              o_tx  <= 1'b1;
              cnt   <= len_in - 32'd1;
            end
          end
          S_BRK_REL: state <= S_IDLE;
          default:   state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed stimulus with a cycle-level scoreboard. Each accepted word
// pushes its expected line waveform (tx level + done flag per clock); the monitor
// pops one entry per cycle and compares tx, done, busy and ready.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] bl;
  logic        fc;
  logic        msb;
  logic [1:0]  mode;
  logic        valid;
  logic [7:0]  word;
  logic        rdy;
  logic        busy;
  logic        done;
  logic        cts;
  logic        brk;
  logic        tx;

  typedef struct packed { logic tx; logic done; } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int lat = 0;
  bit brk_mode = 1'b0;

  uart_tx dut (
    .i_clk(clk), .i_nrst(nrst), .i_bit_length(bl), .i_hw_flow_control_enable(fc),
    .i_msb_first(msb), .i_stop_bit_mode(mode), .i_tx_valid(valid), .i_tx_word(word),
    .o_tx_ready(rdy), .o_tx_busy(busy), .o_tx_done(done),
`ifdef UART_TX_BREAK_EN
    .i_break(brk),
`endif
    .i_cts(cts), .o_tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent model of one frame: 1 entry per clock, done on the last one.
  task automatic push_frame(input logic [7:0] w, input logic [31:0] bl_in, input bit m, input bit two);
    logic [11:0] bits;
    int n;
    int len;
    len = (bl_in == 0) ? 1 : int'(bl_in);
    n = two ? 12 : 11;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = m ? w[7-i] : w[i];
    bits[9] = ^w;
    bits[10] = 1'b1;
    bits[11] = 1'b1;
    for (int b = 0; b < n; b++)
      for (int c = 0; c < len; c++)
        exp_q.push_back('{tx: bits[b], done: (b == n-1 && c == len-1)});
  endtask

  // Monitor: sample mid-cycle, compare against the scoreboard, then log accepts.
  always @(negedge clk) begin
    exp_t e;
    bit   in_frame;
    if (!nrst) begin
      exp_q.delete();
      chk("rst_tx", tx, 1);
      chk("rst_ready", rdy, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end else if (!brk_mode) begin
      in_frame = (exp_q.size() != 0);
      e = in_frame ? exp_q.pop_front() : '{tx: 1'b1, done: 1'b0};
      chk("tx", tx, e.tx);
      chk("done", done, e.done);
      chk("busy", busy, in_frame);
      chk("ready", rdy, !in_frame && (!fc || !cts));
      if (done) begin
        done_cnt++;
        lat = cyc - acc_cyc;
      end
      if (valid && rdy) begin
        acc_cnt++;
        acc_cyc = cyc;
        push_frame(word, bl, msb, mode == 2'b01);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 400) begin step(1); n++; end
    chk("accept_timeout", acc_cnt >= target, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin step(1); n++; end
    chk("idle_timeout", (exp_q.size() == 0) && !busy, 1);
  endtask

  task automatic send(input logic [7:0] w, input logic [31:0] b, input bit m, input logic [1:0] md);
    int a = acc_cnt;
    word = w; bl = b; msb = m; mode = md; valid = 1'b1;
    wait_acc(a + 1);
    valid = 1'b0;
  endtask

  initial begin
    int a;
    int d;
    nrst = 1'b0; bl = 32'd4; fc = 1'b0; msb = 1'b0; mode = 2'b00;
    valid = 1'b0; word = 8'h00; cts = 1'b0; brk = 1'b0;
    step(3);
    chk("reset_ready", rdy, 0);
    nrst = 1'b1;
    step(2);

    // A5, lsb-first, 1 stop, 4 clocks/bit: done 44 cycles after accept
    send(8'hA5, 32'd4, 1'b0, 2'b00);
    wait_idle();
    chk("a5_latency", lat, 44);

    // 81, msb-first, 2 stop, 2 clocks/bit; config changed right after accept
    send(8'h81, 32'd2, 1'b1, 2'b01);
    bl = 32'd7; msb = 1'b0; mode = 2'b00; word = 8'hFF;
    wait_idle();
    chk("81_latency", lat, 24);

    // bit length 0 runs as 1; stop mode 2'b11 means one stop bit
    send(8'h3A, 32'd0, 1'b0, 2'b11);
    wait_idle();
    chk("bl0_latency", lat, 11);

    // flow control: CTS high blocks the start; drop it and the frame goes
    fc = 1'b1; cts = 1'b1; bl = 32'd4; mode = 2'b00; word = 8'h5A; valid = 1'b1;
    a = acc_cnt;
    step(100);
    chk("cts_block", acc_cnt, a);
    cts = 1'b0;
    wait_acc(a + 1);
    valid = 1'b0;
    step(6);
    cts = 1'b1;   // mid-frame deassert must not disturb the frame
    wait_idle();
    step(5);
    chk("cts_hold_idle", acc_cnt, a + 1);
    fc = 1'b0;    // CTS ignored once flow control is off

    // back-to-back with valid held: 00, FF, 55 at 3 clocks/bit
    a = acc_cnt; d = done_cnt;
    bl = 32'd3; msb = 1'b0; mode = 2'b00; word = 8'h00; valid = 1'b1;
    wait_acc(a + 1); word = 8'hFF;
    wait_acc(a + 2); word = 8'h55;
    wait_acc(a + 3); valid = 1'b0;
    wait_idle();
    chk("b2b_done", done_cnt, d + 3);
    chk("b2b_latency", lat, 33);

    // reset during data bit 4: line idles at once, no done pulse
    d = done_cnt;
    send(8'hF0, 32'd4, 1'b0, 2'b00);
    step(21);
    nrst = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    step(3);
    nrst = 1'b1;
    step(20);
    chk("midrst_no_done", done_cnt, d);
    send(8'h3C, 32'd4, 1'b0, 2'b00);
    wait_idle();
    chk("after_rst_done", done_cnt, d + 1);
    chk("after_rst_latency", lat, 44);

`ifdef UART_TX_BREAK_EN
    brk_mode = 1'b1;
    bl = 32'd4; valid = 1'b1; word = 8'h11;
    a = acc_cnt;
    brk = 1'b1;
    step(1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("brk_tx", tx, 0);
      chk("brk_ready", rdy, 0);
    end
    valid = 1'b0;
    @(posedge clk); #1;
    brk = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("brk_rel_tx", tx, 1);
      chk("brk_rel_ready", rdy, 0);
    end
    @(negedge clk);
    chk("brk_ready_back", rdy, 1);
    @(posedge clk); #1;
    brk_mode = 1'b0;
`endif

    step(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
